// File: rtl/mem_realign_pkg.sv
// mem_realign_pkg: shared port-rotation types and helper for the cascade shifter request/response paths.
// MEM_RSP_REALIGN_OUTREG_EN adds one registered response stage to the in-flight window.
package mem_realign_pkg;
    localparam int NR_PORTS = 8;
    localparam int SEL_W = $clog2(NR_PORTS);
`ifdef MEM_RSP_REALIGN_OUTREG_EN
    localparam int OUTREG_STAGES = 1;
`else
    localparam int OUTREG_STAGES = 0;
`endif
    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NR_PORTS-1:0] mask_t;
    typedef struct packed {
        mask_t mask;
        sel_t  sel;
    } stage_t;
    // Power-of-2 port count, so the SEL_W-bit wrap is the modulo.
    function automatic sel_t rot_idx(sel_t i, sel_t sel);
        return i + sel;
    endfunction
endpackage

// File: rtl/mem_sel_delay_line.sv
// mem_sel_delay_line: fixed-depth shift register of {mask, sel} entries matching the memory latency.
module mem_sel_delay_line
    import mem_realign_pkg::*;
#(
    parameter int Depth = 1
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  stage_t i_stage,
    output stage_t o_head
);
    stage_t r_stage [Depth];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < Depth; k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= i_stage;
            for (int k = 1; k < Depth; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign o_head = r_stage[Depth-1];
endmodule

// File: rtl/mem_rsp_realigner.sv
// mem_rsp_realigner: inverse-rotates memory responses back to their issuing ports and counts requests in flight.
// MEM_RSP_REALIGN_OUTREG_EN registers the realigned response (one extra cycle of latency).
module mem_rsp_realigner
    import mem_realign_pkg::*;
#(
    parameter int NrPorts       = 8,
    parameter int DataWidth     = 64,
    parameter int MemoryLatency = 1,
    parameter int SelWidth      = $clog2(NrPorts),
    parameter int CntWidth      = $clog2(NrPorts*(MemoryLatency+OUTREG_STAGES)+1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrPorts-1:0]             req_fire_i,
    input  logic [SelWidth-1:0]            sel_i,
    input  logic [NrPorts*DataWidth-1:0]   out_rdata_i,
    output logic [NrPorts-1:0]             in_rvalid_o,
    output logic [NrPorts*DataWidth-1:0]   in_rdata_o,
    output logic [CntWidth-1:0]            outstanding_o,
    output logic                           busy_o
);
    if (NrPorts != NR_PORTS || MemoryLatency < 1) begin : g_param_err
        $error("mem_rsp_realigner: NrPorts must match the package and MemoryLatency must be >= 1");
    end

    stage_t                         w_issue;
    stage_t                         w_head;
    mask_t                          w_rvalid;
    logic [NrPorts*DataWidth-1:0]   w_rdata;
    logic [CntWidth-1:0]            r_cnt;

    assign w_issue = '{mask: req_fire_i, sel: sel_i};

    mem_sel_delay_line #(.Depth(MemoryLatency)) u_dly (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_stage (w_issue),
        .o_head  (w_head)
    );

    // Unused memory ports are masked so stale data never leaks to an input port.
    for (genvar i = 0; i < NrPorts; i++) begin : g_port
        sel_t w_src;
        assign w_src = rot_idx(sel_t'(i), w_head.sel);
        assign w_rvalid[i] = w_head.mask[w_src];
        assign w_rdata[i*DataWidth +: DataWidth] =
            w_rvalid[i] ? out_rdata_i[w_src*DataWidth +: DataWidth] : '0;
    end

`ifdef MEM_RSP_REALIGN_OUTREG_EN
    logic [NrPorts-1:0]           r_rvalid;
    logic [NrPorts*DataWidth-1:0] r_rdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rvalid;
            r_rdata  <= w_rdata;
        end
    end

    assign in_rvalid_o = r_rvalid;
    assign in_rdata_o  = r_rdata;
`else
    assign in_rvalid_o = w_rvalid;
    assign in_rdata_o  = w_rdata;
`endif

    // Retirement is counted on what is actually presented upstream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_cnt <= '0;
        else       r_cnt <= r_cnt + CntWidth'($countones(req_fire_i)) - CntWidth'($countones(in_rvalid_o));
    end

    assign outstanding_o = r_cnt;
    assign busy_o        = |r_cnt;
endmodule
